// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl: pedestrian WALK/DONT_WALK controller slaved to the vehicle light FSM.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int CLEAR_CYCLES = 6,
    parameter int FLASH_HALF   = 1,
    parameter int CW           = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          red,
    input  logic          yellow,
    input  logic          green,
    input  logic          ped_req,
    output logic          walk,
    output logic          dont_walk,
    output logic          ped_wait,
    output logic [CW-1:0] countdown,
    output logic          fault
);
    localparam int FW = $clog2(FLASH_HALF + 1);
    localparam logic [CW-1:0] TOTAL    = CW'(WALK_CYCLES + CLEAR_CYCLES);
    localparam logic [CW-1:0] WALK_END = CW'(CLEAR_CYCLES + 1);
    localparam logic [FW-1:0] FLASH_END = FW'(FLASH_HALF - 1);

    typedef enum logic [1:0] {IDLE, WALK, CLEAR, FAULT} state_t;

    state_t        state;
    logic          armed;
    logic          vseen;
    logic [FW-1:0] fcnt;
    logic          valid;

    assign valid = (red + yellow + green) == 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            ped_wait  <= 1'b0;
            countdown <= '0;
            fault     <= 1'b0;
            armed     <= 1'b1;
            vseen     <= 1'b0;
            fcnt      <= '0;
        end else begin
            if (!red) armed <= 1'b1;
            if (ped_req && state != WALK) ped_wait <= 1'b1;
            if (!valid) begin
                state     <= FAULT;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                countdown <= '0;
                fault     <= 1'b1;
                vseen     <= 1'b0;
            end else if ((state == WALK || state == CLEAR) && !red) begin
                state     <= IDLE;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                countdown <= '0;
            end else begin
                case (state)
                    FAULT: begin
                        vseen <= 1'b1;
                        if (vseen) begin
                            state <= IDLE;
                            fault <= 1'b0;
                        end
                    end
                    IDLE: if (red && armed && (ped_wait || ped_req)) begin
                        state     <= WALK;
                        walk      <= 1'b1;
                        dont_walk <= 1'b0;
                        countdown <= TOTAL;
                        armed     <= 1'b0;
                        ped_wait  <= 1'b0;
                    end
                    WALK: begin
                        countdown <= countdown - 1'b1;
                        if (countdown == WALK_END) begin
                            state     <= CLEAR;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            fcnt      <= '0;
                        end
                    end
                    CLEAR: begin
                        // countdown reaching 1 marks the last clearance cycle
                        if (countdown <= CW'(1)) begin
                            state     <= IDLE;
                            countdown <= '0;
                            dont_walk <= 1'b1;
                        end else begin
                            countdown <= countdown - 1'b1;
                            fcnt      <= (fcnt == FLASH_END) ? '0 : fcnt + 1'b1;
                            if (fcnt == FLASH_END) dont_walk <= ~dont_walk;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ped_signal_ctrl.sv
// tb_ped_signal_ctrl: directed checks of ped_signal_ctrl with hand-computed expectations.
module tb_ped_signal_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       red = 1'b1, yellow = 1'b0, green = 1'b0, ped_req = 1'b0;
    logic       walk, dont_walk, ped_wait, fault;
    logic [7:0] countdown;
    int         tests = 0, fails = 0;

    ped_signal_ctrl dut (
        .clk(clk), .rst(rst), .red(red), .yellow(yellow), .green(green),
        .ped_req(ped_req), .walk(walk), .dont_walk(dont_walk),
        .ped_wait(ped_wait), .countdown(countdown), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_walk", walk, 0);
        chk("rst_dw", dont_walk, 1);
        chk("rst_wait", ped_wait, 0);
        chk("rst_cd", countdown, 0);
        chk("rst_fault", fault, 0);
        rst = 1'b1;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("grant_walk", walk, 1);
        chk("grant_dw", dont_walk, 0);
        chk("grant_wait", ped_wait, 0);
        for (int i = 0; i < 8; i++) begin
            chk("walk_cd", countdown, 14 - i);
            chk("walk_on", walk, 1);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            chk("clr_cd", countdown, 6 - i);
            chk("clr_dw", dont_walk, (i % 2 == 0) ? 1 : 0);
            chk("clr_walk", walk, 0);
            step();
        end
        chk("end_cd", countdown, 0);
        chk("end_dw", dont_walk, 1);
        chk("end_walk", walk, 0);
        // red never dropped: request must wait for the next red interval
        ped_req = 1'b1;
        step();
        chk("rearm_wait", ped_wait, 1);
        step();
        chk("rearm_nowalk", walk, 0);
        ped_req = 1'b0;
        red = 1'b0; green = 1'b1;
        step();
        chk("green_nowalk", walk, 0);
        chk("green_wait", ped_wait, 1);
        red = 1'b1; green = 1'b0;
        step();
        chk("rearm_walk", walk, 1);
        chk("rearm_clr", ped_wait, 0);
        chk("rearm_cd", countdown, 14);
        step();
        step();
        chk("w3_cd", countdown, 12);
        red = 1'b0; green = 1'b1;
        step();
        chk("abort_walk", walk, 0);
        chk("abort_dw", dont_walk, 1);
        chk("abort_cd", countdown, 0);
        red = 1'b1; green = 1'b0; ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("w2_walk", walk, 1);
        green = 1'b1;
        step();
        chk("flt_fault", fault, 1);
        chk("flt_walk", walk, 0);
        chk("flt_dw", dont_walk, 1);
        chk("flt_cd", countdown, 0);
        green = 1'b0;
        step();
        chk("flt_hold", fault, 1);
        step();
        chk("flt_clear", fault, 0);
        chk("flt_idle_walk", walk, 0);
        red = 1'b0; green = 1'b1; ped_req = 1'b1;
        step();
        chk("g_wait", ped_wait, 1);
        chk("g_nowalk", walk, 0);
        ped_req = 1'b0;
        step();
        chk("g_nowalk2", walk, 0);
        red = 1'b1; green = 1'b0;
        step();
        chk("g_walk", walk, 1);
        chk("g_wait_clr", ped_wait, 0);
        for (int i = 0; i < 9; i++) step();
        chk("mid_clr_cd", countdown, 5);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        chk("clr_req_wait", ped_wait, 1);
        #3 rst = 1'b0;
        #1;
        chk("arst_walk", walk, 0);
        chk("arst_dw", dont_walk, 1);
        chk("arst_cd", countdown, 0);
        chk("arst_wait", ped_wait, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
